// File: rtl/kgp_arith_pkg.sv
// Shared arithmetic types for the KGP_RISC datapath: complement modes, unit states,
// and an elaboration-time geometry check.
package kgp_arith_pkg;

  typedef enum logic [1:0] {
    CMP_ONES = 2'b00,
    CMP_TWOS = 2'b01,
    CMP_ABS  = 2'b10,
    CMP_PASS = 2'b11
  } cmp_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } cmp_state_t;

  // True when an operand of `width` bits splits into whole chunks of `chunk` bits
  function automatic bit chunk_fits(input int unsigned width, input int unsigned chunk);
    return (chunk != 0) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/complement_chunk.sv
// One CHUNK-wide slice of the complement carry chain: (data ^ invert-mask) + carry_in.
module complement_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] data,
  input  logic             invert,
  input  logic             carry_in,
  output logic [CHUNK-1:0] sum,
  output logic             carry_out
);

  // Conditional inversion followed by increment, with the carry-out exposed
  always_comb begin
    {carry_out, sum} = (CHUNK+1)'(data ^ {CHUNK{invert}}) + (CHUNK+1)'(carry_in);
  end

endmodule

// File: rtl/complement_unit.sv
// Multi-cycle ones'/two's complement, absolute value and pass-through unit.
// Processes CHUNK bits per cycle, LSB first, through a registered carry.
// Optional feature macro: COMPLEMENT_SAT_EN (saturate overflowing results to max positive).
module complement_unit
  import kgp_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] inp1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             ovf
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(N - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};

  // Reject operand/chunk geometries that do not tile evenly
  if (!chunk_fits(WIDTH, CHUNK)) begin : g_width_chk
    $error("complement_unit: WIDTH must be a non-zero multiple of CHUNK");
  end

  cmp_state_t       state, state_n;
  cmp_mode_t        mode_q, mode_n;
  logic [WIDTH-1:0] op_q, op_n;
  logic [IDXW-1:0]  idx, idx_n;
  logic             carry, carry_n;
  logic             inv, inv_n;
  logic [WIDTH-1:0] out_n;
  logic             busy_n, done_n, ovf_n;

  logic [CHUNK-1:0] chunk_c;
  logic [CHUNK-1:0] sum_c;
  logic             cout_c;
  logic             ovf_hit_c;

  // Current operand chunk selected by the running index
  assign chunk_c = op_q[32'(idx) * CHUNK +: CHUNK];

  // Only the most-negative operand overflows, and only when negating
  assign ovf_hit_c = (op_q == MOST_NEG) && ((mode_q == CMP_TWOS) || (mode_q == CMP_ABS));

  complement_chunk #(.CHUNK(CHUNK)) u_chunk (
    .data      (chunk_c),
    .invert    (inv),
    .carry_in  (carry),
    .sum       (sum_c),
    .carry_out (cout_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    op_n    = op_q;
    idx_n   = idx;
    carry_n = carry;
    inv_n   = inv;
    out_n   = out;
    busy_n  = busy;
    done_n  = 1'b0;
    ovf_n   = ovf;

    case (state)
      ST_IDLE: begin
        if (start) begin
          op_n    = inp1;
          mode_n  = cmp_mode_t'(mode);
          idx_n   = '0;
          state_n = ST_RUN;
          busy_n  = 1'b1;
          case (cmp_mode_t'(mode))
            CMP_ONES: begin carry_n = 1'b0;               inv_n = 1'b1;               end
            CMP_TWOS: begin carry_n = 1'b1;               inv_n = 1'b1;               end
            CMP_ABS:  begin carry_n = inp1[WIDTH-1];      inv_n = inp1[WIDTH-1];      end
            default:  begin carry_n = 1'b0;               inv_n = 1'b0;               end
          endcase
        end
      end
      ST_RUN: begin
        out_n[32'(idx) * CHUNK +: CHUNK] = sum_c;
        carry_n = cout_c;
        if (idx == LAST_IDX) begin
          state_n = ST_IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          ovf_n   = ovf_hit_c;
`ifdef COMPLEMENT_SAT_EN
          if (ovf_hit_c) begin
            out_n = MAX_POS;
          end
`endif
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      mode_q <= CMP_ONES;
      op_q   <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      inv    <= 1'b0;
      out    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state  <= state_n;
      mode_q <= mode_n;
      op_q   <= op_n;
      idx    <= idx_n;
      carry  <= carry_n;
      inv    <= inv_n;
      out    <= out_n;
      busy   <= busy_n;
      done   <= done_n;
      ovf    <= ovf_n;
    end
  end

  // MAX_POS is only referenced when saturation is built in
  logic unused_c;
  assign unused_c = ^MAX_POS;

endmodule

// File: tb/tb_complement_unit.sv
// Self-checking bench for complement_unit: vector table, random operands, handshake
// corner cases and mid-run reset, with a queue of expected results.
module tb_complement_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] inp1;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic        ovf;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] inp;
    logic [31:0] out;
    logic        ovf;
  } vec_t;

  typedef struct packed {
    logic [31:0] out;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[11];

  complement_unit #(.WIDTH(32), .CHUNK(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .inp1  (inp1),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic exp_t model(input logic [1:0] m, input logic [31:0] x);
    exp_t r;
    r.ovf = ((m == 2'b01) || (m == 2'b10)) && (x == 32'h8000_0000);
    case (m)
      2'b00:   r.out = ~x;
      2'b01:   r.out = 32'd0 - x;
      2'b10:   r.out = x[31] ? (32'd0 - x) : x;
      default: r.out = x;
    endcase
`ifdef COMPLEMENT_SAT_EN
    if (r.ovf) r.out = 32'h7FFF_FFFF;
`endif
    return r;
  endfunction

  // Drive a start at the current negedge, release it one cycle later
  task automatic start_op(input logic [1:0] m, input logic [31:0] x);
    start = 1'b1;
    mode  = m;
    inp1  = x;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count negedges until done is seen, bounded
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Pop the oldest expected result and compare it against the DUT
  task automatic pop_check(input string name);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      $display("FAIL %s_queue: got empty scoreboard, expected an entry", name);
      return;
    end
    passed++;
    e = sb.pop_front();
    chk({name, "_out"}, out, e.out);
    chk({name, "_ovf"}, 32'(ovf), 32'(e.ovf));
  endtask

  initial begin
    int    lat;
    bit    seen;
    exp_t  e;
    logic [1:0]  rm;
    logic [31:0] rx;

`ifdef COMPLEMENT_SAT_EN
    localparam logic [31:0] SAT_OUT = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] SAT_OUT = 32'h8000_0000;
`endif

    vecs[0]  = '{2'b01, 32'h0000_0020, 32'hFFFF_FFE0, 1'b0};
    vecs[1]  = '{2'b00, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF6, 32'h0000_000A, 1'b0};
    vecs[3]  = '{2'b10, 32'h0000_000A, 32'h0000_000A, 1'b0};
    vecs[4]  = '{2'b01, 32'h8000_0000, SAT_OUT,       1'b1};
    vecs[5]  = '{2'b01, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[6]  = '{2'b11, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[7]  = '{2'b10, 32'h8000_0000, SAT_OUT,       1'b1};
    vecs[8]  = '{2'b00, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0};
    vecs[9]  = '{2'b01, 32'h0000_0100, 32'hFFFF_FF00, 1'b0};
    vecs[10] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    mode  = 2'b00;
    inp1  = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out",  out,       32'd0);
    chk("rst_ovf",  32'(ovf),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors; inputs are scrambled during RUN and must not matter
    for (int i = 0; i < 11; i++) begin
      sb.push_back('{out: vecs[i].out, ovf: vecs[i].ovf});
      start_op(vecs[i].mode, vecs[i].inp);
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
      mode = ~vecs[i].mode;
      inp1 = ~vecs[i].inp;
      wait_done(lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      pop_check($sformatf("vec%0d", i));
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
    end

    // Random operands against the model
    for (int i = 0; i < 8; i++) begin
      rm = 2'($urandom_range(0, 3));
      rx = $urandom;
      if (i == 0) rx = 32'h8000_0000;
      e = model(rm, rx);
      sb.push_back(e);
      start_op(rm, rx);
      wait_done(lat);
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'd4);
      pop_check($sformatf("rnd%0d", i));
      @(negedge clk);
    end

    // Start while busy is ignored; start on the done cycle is accepted
    sb.push_back('{out: 32'hFFFF_FF01, ovf: 1'b0});
    start_op(2'b01, 32'h0000_00FF);
    start = 1'b1;
    mode  = 2'b11;
    inp1  = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("busy_ignore_latency", 32'(lat), 32'd3);
    pop_check("busy_ignore");
    sb.push_back('{out: 32'h5555_AAAA, ovf: 1'b0});
    start_op(2'b00, 32'hAAAA_5555);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done_low", 32'(done), 32'd0);
    wait_done(lat);
    chk("b2b_latency", 32'(lat), 32'd4);
    pop_check("b2b");
    @(negedge clk);

    // Leave ovf set and out non-zero, then reset two cycles into RUN
    sb.push_back('{out: SAT_OUT, ovf: 1'b1});
    start_op(2'b10, 32'h8000_0000);
    wait_done(lat);
    pop_check("pre_reset");
    @(negedge clk);
    start_op(2'b01, 32'h1234_5678);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_out",  out,       32'd0);
    chk("midrst_ovf",  32'(ovf),  32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    chk("midrst_no_done", 32'(seen), 32'd0);

    // Unit still works after the aborted operation
    sb.push_back('{out: 32'hEDCB_A988, ovf: 1'b0});
    start_op(2'b01, 32'h1234_5678);
    wait_done(lat);
    chk("post_rst_latency", 32'(lat), 32'd4);
    pop_check("post_rst");

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
